// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Synchronous front end for an asynchronous byte-wide SRAM. Accepts single
//   byte read/write requests through a req/done handshake and sequences the
//   SRAM strobes: one address-setup cycle, WAIT_CYCLES of strobe-low access
//   and one recovery (bus turnaround) cycle.
//
//   Handshake: req/wr/addr_in/wdata are sampled only on a clock edge where the
//   controller is idle (busy=0 and not in the recovery cycle); a request seen
//   at any other time is dropped, not queued. Completion is a one-cycle done
//   pulse; rdata holds the read byte from done until the next read completes.
//   busy is high from the cycle after acceptance through the done cycle.
//
// Parameters
//   ADDRLEN      SRAM address width.
//   WAIT_CYCLES  Cycles oe_/we_ are held low (minimum 1).
//
// Ports
//   clk        system clock, rising edge
//   rst_       asynchronous reset, active low
//   req        request strobe
//   wr         1 = write, 0 = read
//   addr_in    request address
//   wdata      write byte
//   rdata      read byte
//   done       one-cycle completion pulse
//   busy       access in progress
//   oe_        SRAM output enable, active low
//   we_        SRAM write enable, active low
//   addr       SRAM address (registered)
//   data       SRAM data bus, driven only during writes
//   dbg_state  current FSM state (IDLE=0, SETUP=1, ACCESS=2, RECOVER=3)
//   dbg_drive  registered tri-state enable of the data bus
//
// Optional feature
//   MEM_CTRL_RDCACHE_EN: one-entry read cache. A read hitting the cached
//   address completes in one cycle with no SRAM strobe; a read miss fills the
//   entry; a write to the cached address updates the cached byte.
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDRLEN     = 8,
   parameter int WAIT_CYCLES = 6
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               req,
   input  logic               wr,
   input  logic [ADDRLEN-1:0] addr_in,
   input  logic [7:0]         wdata,
   output logic [7:0]         rdata,
   output logic               done,
   output logic               busy,
   output logic               oe_,
   output logic               we_,
   output logic [ADDRLEN-1:0] addr,
   inout  wire  [7:0]         data,
   output logic [1:0]         dbg_state,
   output logic               dbg_drive
);

   // Counter holds WAIT_CYCLES-1 down to 0.
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 wr_q, wr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 drive_q, drive_d;
   logic [ADDRLEN-1:0]   addr_q, addr_d;
   logic                 oe_q, oe_d;
   logic                 we_q, we_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic [7:0]           rdata_q, rdata_d;

   logic                 cache_hit;
   logic [7:0]           hit_byte;

`ifdef MEM_CTRL_RDCACHE_EN
   logic                 c_valid_q, c_valid_d;
   logic [ADDRLEN-1:0]   c_tag_q, c_tag_d;
   logic [7:0]           c_byte_q, c_byte_d;

   assign cache_hit = !wr && c_valid_q && (c_tag_q == addr_in);
   assign hit_byte  = c_byte_q;
`else
   assign cache_hit = 1'b0;
   assign hit_byte  = 8'h00;
`endif

   // Controller drives the bus only from the registered enable, so the bus is
   // released on the same edge that returns to IDLE, long before any oe_ fall.
   assign data = drive_q ? wdata_q : 8'bz;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      drive_d = drive_q;
      addr_d  = addr_q;
      oe_d    = oe_q;
      we_d    = we_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      rdata_d = rdata_q;
`ifdef MEM_CTRL_RDCACHE_EN
      c_valid_d = c_valid_q;
      c_tag_d   = c_tag_q;
      c_byte_d  = c_byte_q;
`endif

      case (state_q)
         IDLE: begin
            busy_d  = 1'b0;
            drive_d = 1'b0;
            if (req) begin
               busy_d = 1'b1;
               if (cache_hit) begin
                  // Served from the cache: the RECOVER state doubles as the
                  // single done/busy cycle, strobes never move.
                  rdata_d = hit_byte;
                  done_d  = 1'b1;
                  state_d = RECOVER;
               end else begin
                  wr_d    = wr;
                  wdata_d = wdata;
                  addr_d  = addr_in;
                  drive_d = wr;
                  state_d = SETUP;
               end
            end
         end

         SETUP: begin
            // Address has been stable for a full cycle; open the strobe.
            cnt_d   = CNT_LOAD;
            oe_d    = wr_q;
            we_d    = !wr_q;
            state_d = ACCESS;
         end

         ACCESS: begin
            if (cnt_q == '0) begin
               oe_d    = 1'b1;
               we_d    = 1'b1;
               done_d  = 1'b1;
               state_d = RECOVER;
               if (!wr_q) begin
                  // Sampled on the edge that closes the last strobe-low cycle.
                  rdata_d = data;
               end
`ifdef MEM_CTRL_RDCACHE_EN
               if (!wr_q) begin
                  c_valid_d = 1'b1;
                  c_tag_d   = addr_q;
                  c_byte_d  = data;
               end else if (c_valid_q && (c_tag_q == addr_q)) begin
                  c_byte_d  = wdata_q;
               end
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RECOVER: begin
            // Write data is held through this cycle; bus released after it.
            busy_d  = 1'b0;
            drive_d = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= 8'h00;
         drive_q <= 1'b0;
         addr_q  <= '0;
         oe_q    <= 1'b1;
         we_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 8'h00;
`ifdef MEM_CTRL_RDCACHE_EN
         c_valid_q <= 1'b0;
         c_tag_q   <= '0;
         c_byte_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         drive_q <= drive_d;
         addr_q  <= addr_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
`ifdef MEM_CTRL_RDCACHE_EN
         c_valid_q <= c_valid_d;
         c_tag_q   <= c_tag_d;
         c_byte_q  <= c_byte_d;
`endif
      end
   end

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign oe_       = oe_q;
   assign we_       = we_q;
   assign addr      = addr_q;
   assign dbg_state = state_q;
   assign dbg_drive = drive_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//   Directed bench for mem_ctrl with a behavioural asynchronous SRAM
//   (54 ns access time, write on the rising edge of we_).
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

`ifdef MEM_CTRL_RDCACHE_EN
   localparam logic CACHE = 1'b1;
`else
   localparam logic CACHE = 1'b0;
`endif

   logic       clk;
   logic       rst_;
   logic       req;
   logic       wr;
   logic [7:0] addr_in;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       done;
   logic       busy;
   logic       oe_;
   logic       we_;
   logic [7:0] addr;
   wire  [7:0] data;
   logic [1:0] dbg_state;
   logic       dbg_drive;

   int n_checks = 0;
   int n_errors = 0;

   mem_ctrl #(.ADDRLEN(8), .WAIT_CYCLES(6)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .req       (req),
      .wr        (wr),
      .addr_in   (addr_in),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .busy      (busy),
      .oe_       (oe_),
      .we_       (we_),
      .addr      (addr),
      .data      (data),
      .dbg_state (dbg_state),
      .dbg_drive (dbg_drive)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   logic [7:0] mem [256];
   logic [7:0] sram_q;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      sram_q = 8'h00;
   end

   assign data = (!oe_ && we_) ? sram_q : 8'bz;

   always @(negedge oe_) begin
      sram_q = 8'h00;
      #54;
      sram_q = mem[addr];
   end

   always @(posedge we_) begin
      mem[addr] = data;
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request, then 10 observed cycles (cycle c = period after edge c,
   // edge 0 being the acceptance edge). Ends at the start of cycle 11.
   task automatic run_access(input logic w, input logic [7:0] a, input logic [7:0] wd,
                             input logic [7:0] exp_rd, input logic hit);
      logic exp_oe, exp_we, exp_done, exp_busy, exp_drv;
      req = 1'b1; wr = w; addr_in = a; wdata = wd;
      @(posedge clk); #1;
      // Later input changes must not disturb the access.
      req = 1'b0; wr = ~w; addr_in = ~a; wdata = ~wd;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (hit) begin
            exp_done = (c == 1);
            exp_busy = (c == 1);
            exp_oe   = 1'b1;
            exp_we   = 1'b1;
            exp_drv  = 1'b0;
         end else begin
            exp_done = (c == 8);
            exp_busy = (c <= 8);
            exp_oe   = !(!w && c >= 2 && c <= 7);
            exp_we   = !(w && c >= 2 && c <= 7);
            exp_drv  = w && (c <= 8);
         end
         check($sformatf("a%0h c%0d oe_", a, c),  32'(oe_),       32'(exp_oe));
         check($sformatf("a%0h c%0d we_", a, c),  32'(we_),       32'(exp_we));
         check($sformatf("a%0h c%0d done", a, c), 32'(done),      32'(exp_done));
         check($sformatf("a%0h c%0d busy", a, c), 32'(busy),      32'(exp_busy));
         check($sformatf("a%0h c%0d drv", a, c),  32'(dbg_drive), 32'(exp_drv));
         if (!hit && c <= 9)
            check($sformatf("a%0h c%0d addr", a, c), 32'(addr), 32'(a));
         if (exp_drv)
            check($sformatf("a%0h c%0d data", a, c), 32'(data), 32'(wd));
         if (!w && (hit || c >= 8))
            check($sformatf("a%0h c%0d rdata", a, c), 32'(rdata), 32'(exp_rd));
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_ = 1'b0; req = 1'b0; wr = 1'b0; addr_in = 8'h00; wdata = 8'h00;

      // Reset state
      #12;
      check("rst oe_",   32'(oe_),       32'd1);
      check("rst we_",   32'(we_),       32'd1);
      check("rst busy",  32'(busy),      32'd0);
      check("rst done",  32'(done),      32'd0);
      check("rst rdata", 32'(rdata),     32'd0);
      check("rst addr",  32'(addr),      32'd0);
      check("rst drv",   32'(dbg_drive), 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      @(negedge clk); rst_ = 1'b1;
      @(posedge clk); #1;

      // Write then read back
      run_access(1'b1, 8'h12, 8'hA5, 8'h00, 1'b0);
      run_access(1'b0, 8'h12, 8'h00, 8'hA5, 1'b0);

      // Request held while busy is ignored, taken in the first idle cycle
      req = 1'b1; wr = 1'b1; addr_in = 8'h20; wdata = 8'h66;
      @(posedge clk); #1;
      for (int c = 1; c <= 18; c++) begin
         if (c >= 3 && c <= 9) begin
            req = 1'b1; wr = 1'b1; addr_in = 8'h34; wdata = 8'h5A;
         end else begin
            req = 1'b0;
         end
         @(negedge clk);
         if (c == 8) begin
            check("busy c8 done", 32'(done), 32'd1);
            check("busy c8 addr", 32'(addr), 32'h20);
         end
         if (c == 9) begin
            check("busy c9 busy", 32'(busy), 32'd0);
            check("busy c9 done", 32'(done), 32'd0);
            check("busy c9 addr", 32'(addr), 32'h20);
         end
         if (c == 10) begin
            check("busy c10 busy", 32'(busy), 32'd1);
            check("busy c10 addr", 32'(addr), 32'h34);
         end
         if (c == 11) check("busy c11 we_", 32'(we_), 32'd0);
         if (c == 16) check("busy c16 we_", 32'(we_), 32'd0);
         if (c == 16) check("busy c16 done", 32'(done), 32'd0);
         if (c == 17) begin
            check("busy c17 done", 32'(done), 32'd1);
            check("busy c17 we_",  32'(we_),  32'd1);
         end
         if (c == 18) check("busy c18 busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
      end
      run_access(1'b0, 8'h34, 8'h00, 8'h5A, 1'b0);
      run_access(1'b0, 8'h20, 8'h00, 8'h66, 1'b0);

      // Reset in the middle of a write
      req = 1'b1; wr = 1'b1; addr_in = 8'h40; wdata = 8'h77;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("mid we_ before rst", 32'(we_),       32'd0);
      check("mid drv before rst", 32'(dbg_drive), 32'd1);
      rst_ = 1'b0;
      #1;
      check("mid rst we_",   32'(we_),       32'd1);
      check("mid rst oe_",   32'(oe_),       32'd1);
      check("mid rst drv",   32'(dbg_drive), 32'd0);
      check("mid rst busy",  32'(busy),      32'd0);
      check("mid rst done",  32'(done),      32'd0);
      check("mid rst rdata", 32'(rdata),     32'd0);
      check("mid rst state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      @(negedge clk); rst_ = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("post rst c%0d done", c), 32'(done), 32'd0);
         check($sformatf("post rst c%0d busy", c), 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      run_access(1'b0, 8'h40, 8'h00, mem[8'h40], 1'b0);

      // Repeated read, write-through, write elsewhere
      run_access(1'b0, 8'h12, 8'h00, 8'hA5, 1'b0);
      run_access(1'b0, 8'h12, 8'h00, 8'hA5, CACHE);
      run_access(1'b1, 8'h12, 8'hC3, 8'h00, 1'b0);
      run_access(1'b0, 8'h12, 8'h00, 8'hC3, CACHE);
      run_access(1'b1, 8'h55, 8'h11, 8'h00, 1'b0);
      run_access(1'b0, 8'h12, 8'h00, 8'hC3, CACHE);

      // All-ones address
      run_access(1'b1, 8'hFF, 8'h81, 8'h00, 1'b0);
      run_access(1'b0, 8'hFF, 8'h00, 8'h81, 1'b0);
      run_access(1'b0, 8'h55, 8'h00, 8'h11, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
